// File: rtl/csa_pair_resolver.sv
// Resolves a carry-save (sum, carry) vector pair into one binary sum, CHUNK bits per cycle,
// with the chunk carry held in a register. Define CSA_RES_CARRY_OUT_EN to add the out_cout port.
module csa_pair_resolver #(
  parameter int WIDTH = 31,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef CSA_RES_CARRY_OUT_EN
  output logic             out_cout,
`endif
  output logic [WIDTH-1:0] out_sum
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int LAST_W = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
`ifdef CSA_RES_CARRY_OUT_EN
  logic               cout_q, cout_d;
`endif

  logic [31:0]        shamt;
  logic [CHUNK-1:0]   chunk_a, chunk_b;
  logic [CHUNK:0]     chunk_sum;
  logic               last_chunk;
  logic               chunk_cout;
  logic [WIDTH-1:0]   chunk_mask, chunk_ins;

  // Operand slice for chunk idx_q; bits above WIDTH-1 shift in as zero, so the
  // partial last chunk's carry lands exactly on bit LAST_W of chunk_sum.
  always_comb begin
    shamt      = 32'(idx_q) * CHUNK;
    chunk_a    = CHUNK'(a_q >> shamt);
    chunk_b    = CHUNK'(b_q >> shamt);
    chunk_sum  = {1'b0, chunk_a} + {1'b0, chunk_b} + (CHUNK+1)'(carry_q);
    last_chunk = (idx_q == IDX_W'(NCHUNK - 1));
    chunk_cout = last_chunk ? chunk_sum[LAST_W] : chunk_sum[CHUNK];
    chunk_mask = WIDTH'({CHUNK{1'b1}}) << shamt;
    chunk_ins  = WIDTH'(chunk_sum[CHUNK-1:0]) << shamt;
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
`ifdef CSA_RES_CARRY_OUT_EN
    cout_d  = cout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in0;
          b_d     = in1;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d   = (sum_q & ~chunk_mask) | chunk_ins;
        carry_d = chunk_cout;
        idx_d   = idx_q + 1'b1;
        if (last_chunk) begin
          state_d = DONE;
`ifdef CSA_RES_CARRY_OUT_EN
          cout_d  = chunk_cout;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
`ifdef CSA_RES_CARRY_OUT_EN
      cout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
`ifdef CSA_RES_CARRY_OUT_EN
      cout_q  <= cout_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
`ifdef CSA_RES_CARRY_OUT_EN
  assign out_cout  = cout_q;
`endif

endmodule

// File: tb/tb_csa_pair_resolver.sv
// Directed bench for csa_pair_resolver: default CHUNK=8 instance plus a CHUNK=31 instance.
// out_cout checks are compiled in only when CSA_RES_CARRY_OUT_EN is defined.
module tb_csa_pair_resolver;

  localparam int WIDTH = 31;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in0, in1, out_sum;
  logic             in_valid2, in_ready2, out_valid2, out_ready2;
  logic [WIDTH-1:0] in0_2, in1_2, out_sum2;
`ifdef CSA_RES_CARRY_OUT_EN
  logic             out_cout, out_cout2;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csa_pair_resolver #(.WIDTH(WIDTH), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef CSA_RES_CARRY_OUT_EN
    .out_cout  (out_cout),
`endif
    .out_sum   (out_sum)
  );

  csa_pair_resolver #(.WIDTH(WIDTH), .CHUNK(31)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in0       (in0_2),
    .in1       (in1_2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
`ifdef CSA_RES_CARRY_OUT_EN
    .out_cout  (out_cout2),
`endif
    .out_sum   (out_sum2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits a bounded number of edges for out_valid; returns edges after the accept edge.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    int n;
    in0 = a; in1 = b; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_ready_pre"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, "_ready_busy"}, 32'(in_ready), 32'd0);
    wait_valid(n);
    // out_valid first sampled at accept edge + NCHUNK + 1
    check({tag, "_latency"}, 32'(n + 1), 32'd5);
    check({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
    check({tag, "_ready_done"}, 32'(in_ready), 32'd0);
`ifdef CSA_RES_CARRY_OUT_EN
    check({tag, "_cout"}, 32'(out_cout), 32'(exp_cout));
`else
    if (exp_cout === 1'bx) $display("unused expected carry");
`endif
    tick();
    check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in0 = '0; in1 = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; in0_2 = '0; in1_2 = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_in_ready2", 32'(in_ready2), 32'd1);
`ifdef CSA_RES_CARRY_OUT_EN
    check("rst_out_cout", 32'(out_cout), 32'd0);
`endif

    run_op("basic", 31'h12345678, 31'h0EDCBA98, 31'h21111110, 1'b0);
    run_op("chunk_carry", 31'h000000FF, 31'h00000001, 31'h00000100, 1'b0);
    run_op("wrap", 31'h7FFFFFFF, 31'h00000001, 31'h00000000, 1'b1);
    run_op("mid_chunks", 31'h00FFFF00, 31'h00000100, 31'h01000000, 1'b0);

    // Backpressure: result held while out_ready low, new operands refused.
    in0 = 31'd1; in1 = 31'd2; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    check("bp_latency", 32'(n + 1), 32'd5);
    in0 = 31'd7; in1 = 31'd8; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_sum_hold", 32'(out_sum), 32'd3);
      check("bp_no_accept", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_next_accepted", 32'(in_ready), 32'd0);
    wait_valid(n);
    check("bp_next_latency", 32'(n + 1), 32'd5);
    check("bp_next_sum", 32'(out_sum), 32'h0000000F);
    tick();

    // Reset during BUSY discards the in-flight result.
    in0 = 31'h11111111; in1 = 31'h22222222; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_sum", 32'(out_sum), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end
    run_op("after_rst", 31'd5, 31'd6, 31'h0000000B, 1'b0);

    // CHUNK == WIDTH instance: single BUSY cycle.
    in0_2 = 31'h40000000; in1_2 = 31'h3FFFFFFF; in_valid2 = 1'b1; out_ready2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    in0_2 = 31'h0; in1_2 = 31'h0;
    n = 0;
    while (!out_valid2 && n < 20) begin
      tick();
      n++;
    end
    check("wide_latency", 32'(n + 1), 32'd2);
    check("wide_sum", 32'(out_sum2), 32'h7FFFFFFF);
`ifdef CSA_RES_CARRY_OUT_EN
    check("wide_cout", 32'(out_cout2), 32'd0);
`endif
    tick();
    check("wide_idle", 32'(in_ready2), 32'd1);
    in0_2 = 31'h7FFFFFFF; in1_2 = 31'h00000001; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 20) begin
      tick();
      n++;
    end
    check("wide_wrap_latency", 32'(n + 1), 32'd2);
    check("wide_wrap_sum", 32'(out_sum2), 32'h00000000);
`ifdef CSA_RES_CARRY_OUT_EN
    check("wide_wrap_cout", 32'(out_cout2), 32'd1);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
